// File: rtl/mult_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned MultWidth  = 32;
    localparam int unsigned CountWidth = $clog2(MultWidth);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mult_state_e;

endpackage

// File: rtl/cla_adder_32.sv
// Two-level carry-lookahead adder: 4-bit groups with group generate/propagate lookahead.
module cla_adder_32
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MultWidth
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned GrpW   = 4;
    localparam int unsigned NumGrp = WIDTH / GrpW;

    logic [WIDTH-1:0]  g;
    logic [WIDTH-1:0]  p;
    logic [WIDTH:0]    c;
    logic [NumGrp-1:0] grp_g;
    logic [NumGrp-1:0] grp_p;
    logic [NumGrp:0]   grp_c;

    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        grp_g = '0;
        grp_p = '1;
        grp_c = '0;
        c     = '0;
        for (int j = 0; j < int'(NumGrp); j++) begin
            for (int k = 0; k < int'(GrpW); k++) begin
                grp_g[j] = g[j*GrpW+k] | (p[j*GrpW+k] & grp_g[j]);
                grp_p[j] = grp_p[j] & p[j*GrpW+k];
            end
        end
        grp_c[0] = cin_i;
        for (int j = 0; j < int'(NumGrp); j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        // Group boundaries take the lookahead carry; interior bits chain within the group.
        for (int i = 0; i <= int'(WIDTH); i++) begin
            if ((i % GrpW) == 0) begin
                c[i] = grp_c[i/GrpW];
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
        sum_o  = p ^ c[WIDTH-1:0];
        cout_o = c[WIDTH];
    end

endmodule

// File: rtl/multu.sv
// Sequential unsigned multiplier: radix-2 shift-add, one multiplier bit per clock,
// low WIDTH bits of the product held in Out until the next start.
module multu
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             doMult,
    output logic [WIDTH-1:0] Out,
    output logic             mult_done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_e      state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout_unused;

    assign addend = mplier_q[0] ? mcand_q : '0;

    cla_adder_32 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout_unused)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        out_d    = out_q;
        done_d   = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (doMult) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = '0;
                    done_d   = 1'b0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                // No early exit: the last bit is always processed on count WIDTH-1.
                if (count_q == CntW'(WIDTH - 1)) begin
                    out_d   = sum;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

    assign Out       = out_q;
    assign mult_done = done_q;

endmodule

// File: tb/tb_multu.sv
// Directed, table-driven bench for multu with hand-written multi-cycle corner cases.
module tb_multu;

    localparam int Latency = 32;
    localparam int MaxWait = 40;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        doMult;
    logic [31:0] Out;
    logic        mult_done;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [9];

    multu dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .doMult    (doMult),
        .Out       (Out),
        .mult_done (mult_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start request; returns #1 after the load edge with doMult dropped unless held.
    task automatic start(input logic [31:0] va, input logic [31:0] vb, input bit hold);
        @(negedge clk);
        a      = va;
        b      = vb;
        doMult = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) doMult = 1'b0;
    endtask

    // Count edges until mult_done; also checks Out held its prior value meanwhile.
    task automatic wait_done(input logic [31:0] prev, output int edges, output bit held);
        edges = 0;
        held  = 1'b1;
        for (int i = 0; i < MaxWait; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (mult_done) break;
            if (Out !== prev) held = 1'b0;
        end
    endtask

    initial begin
        int          edges;
        bit          held;
        logic [31:0] prev;

        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{32'd1,        32'd5,        32'd5};
        vecs[1] = '{32'd12345,    32'd1000,     32'd12345000};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'h00000000};
        vecs[4] = '{32'h00000000, 32'h12345678, 32'h00000000};
        vecs[5] = '{32'h00000003, 32'h55555555, 32'hFFFFFFFF};
        vecs[6] = '{32'h12345678, 32'h00000010, 32'h23456780};
        vecs[7] = '{32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF};
        vecs[8] = '{32'h80000000, 32'h00000002, 32'h00000000};

        reset  = 1'b1;
        a      = '0;
        b      = '0;
        doMult = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", Out, 32'h0);
        chk("reset_done", {31'b0, mult_done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        prev = 32'h0;
        for (int v = 0; v < 9; v++) begin
            start(vecs[v].a, vecs[v].b, 1'b0);
            chk($sformatf("v%0d_done_drop", v), {31'b0, mult_done}, 32'h0);
            a = ~vecs[v].a;
            b = ~vecs[v].b;
            wait_done(prev, edges, held);
            chk($sformatf("v%0d_latency", v), edges, Latency);
            chk($sformatf("v%0d_hold", v), {31'b0, held}, 32'h1);
            chk($sformatf("v%0d_out", v), Out, vecs[v].prod);
            prev = vecs[v].prod;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_stays", v), {31'b0, mult_done}, 32'h1);
        end

        // A second start while busy must be ignored.
        start(32'd7, 32'd6, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        a      = 32'd3;
        b      = 32'd3;
        doMult = 1'b1;
        @(posedge clk);
        #1;
        doMult = 1'b0;
        wait_done(prev, edges, held);
        chk("ignore_latency", edges, Latency - 11);
        chk("ignore_out", Out, 32'd42);

        // Asynchronous reset mid-operation clears outputs without waiting for a clock edge.
        start(32'd9, 32'd9, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out", Out, 32'h0);
        chk("async_rst_done", {31'b0, mult_done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (Latency + 2) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'b0, mult_done}, 32'h0);
        start(32'd9, 32'd9, 1'b0);
        wait_done(32'h0, edges, held);
        chk("post_rst_latency", edges, Latency);
        chk("post_rst_out", Out, 32'd81);

        // doMult held high restarts on the edge after completion.
        start(32'd2, 32'd3, 1'b1);
        wait_done(32'd81, edges, held);
        chk("hold_latency", edges, Latency);
        chk("hold_out", Out, 32'd6);
        @(posedge clk);
        #1;
        chk("hold_restart_drop", {31'b0, mult_done}, 32'h0);
        doMult = 1'b0;
        wait_done(32'd6, edges, held);
        chk("hold_relatency", edges, Latency);
        chk("hold_reout", Out, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
